// File: rtl/hex_display_scan_pkg.sv
// Shared constants for the hex seven-segment scanner.
// Segment bit order everywhere: bit0=a, bit1=b, ... bit6=g; a 0 bit lights the segment.
package hex_display_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/hex_display_scan_seg7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_decode
  import hex_display_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed N-digit hex display driver: shadow/display double buffer swapped at
// frame end, blanking window at the start of each slot, leading-zero suppression.
module hex_display_scan
  import hex_display_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  terminal, frame_end, show;
  logic [NUM_DIGITS-1:0] suppress;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_glyph;

  assign terminal  = (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_end = terminal && (idx_q == IW'(NUM_DIGITS - 1));

  // A digit is dark when it and every more-significant nibble are zero; digit 0 always shows.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_first
      assign suppress[gi] = 1'b0;
    end else begin : g_upper
      assign suppress[gi] = lz_en && (disp_val_q[VW-1:4*gi] == '0);
    end
  end

  assign cur_nibble = disp_val_q[{idx_q, 2'b00} +: 4];
  assign show = enable && (presc_q >= PW'(BLANK_CYCLES)) && !suppress[idx_q];

  seg7_decode u_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_glyph)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_n_d[gi] = !(show && (idx_q == IW'(gi)));
  end

  always_comb begin
    presc_d      = terminal ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (terminal) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end
    // A load landing on the frame-end cycle bypasses the shadow so it is not lost a frame.
    if (frame_end) begin
      disp_val_d = load ? value : shadow_val_q;
      disp_dp_d  = load ? dp_in : shadow_dp_q;
    end
    seg_d        = show ? cur_glyph : SEG_BLANK;
    dp_n_d       = show ? ~disp_dp_q[idx_q] : 1'b1;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
